// File: rtl/bcd_serial_add_ctrl.sv
// bcd_serial_add_ctrl
//   Adds two packed-BCD operands one digit per clock, least-significant
//   digit first, through a single shared BCD digit adder.
//
// Ports
//   Clock      in   system clock, rising edge
//   Resetn     in   asynchronous active-low reset
//   start      in   operation request, honoured only in IDLE or DONE
//   A, B       in   packed BCD operands (digit i = X[4i+3:4i])
//   Cin        in   carry into digit 0
//   busy       out  high while digits are being added
//   done       out  one-cycle pulse, result valid
//   err        out  an operand digit was > 9; held until next accepted start
//   Sum        out  packed BCD result (partial during ADD, upper digits 0)
//   Cout       out  carry out of the top digit
//   digit_idx  out  index of the digit being added
module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4,
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   A,
    input  logic [4*DIGITS-1:0]   B,
    input  logic                  Cin,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [4*DIGITS-1:0]   Sum,
    output logic                  Cout,
    output logic [IDX_W-1:0]      digit_idx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t              state;
    logic [4*DIGITS-1:0] a_reg;
    logic [4*DIGITS-1:0] b_reg;
    logic                carry;

    logic [3:0]          a_digit;
    logic [3:0]          b_digit;
    logic [4:0]          raw_sum;
    logic [3:0]          sum_digit;
    logic                carry_next;
    logic                operand_bad;

    // Shared single-digit BCD adder working on the latched operands.
    always_comb begin
        a_digit    = a_reg[4*int'(digit_idx) +: 4];
        b_digit    = b_reg[4*int'(digit_idx) +: 4];
        raw_sum    = {1'b0, a_digit} + {1'b0, b_digit} + {4'b0000, carry};
        sum_digit  = raw_sum[3:0];
        carry_next = 1'b0;
        if (raw_sum > 5'd9) begin
            // +6 skips the six unused codes; only the low nibble is kept
            sum_digit  = raw_sum[3:0] + 4'd6;
            carry_next = 1'b1;
        end
    end

    // Validation looks at the live inputs because it decides the accept path.
    always_comb begin
        operand_bad = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (A[4*i +: 4] > 4'd9 || B[4*i +: 4] > 4'd9) begin
                operand_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state     <= S_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            Sum       <= '0;
            Cout      <= 1'b0;
            digit_idx <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_reg     <= A;
                        b_reg     <= B;
                        carry     <= Cin;
                        Sum       <= '0;
                        Cout      <= 1'b0;
                        digit_idx <= '0;
                        if (operand_bad) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            err   <= 1'b0;
                            busy  <= 1'b1;
                            state <= S_ADD;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end

                S_ADD: begin
                    Sum[4*int'(digit_idx) +: 4] <= sum_digit;
                    carry <= carry_next;
                    if (digit_idx == LAST_IDX) begin
                        Cout  <= carry_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        digit_idx <= digit_idx + IDX_W'(1);
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Testbench for bcd_serial_add_ctrl: a 4-digit and a 1-digit instance,
// checked against a decimal reference model.
`timescale 1ns/1ps
module tb_bcd_serial_add_ctrl;

    logic        Clock  = 1'b0;
    logic        Resetn = 1'b1;

    logic        start = 1'b0;
    logic [15:0] A     = '0;
    logic [15:0] B     = '0;
    logic        Cin   = 1'b0;
    logic        busy, done, err, Cout;
    logic [15:0] Sum;
    logic [1:0]  digit_idx;

    logic        start1 = 1'b0;
    logic [3:0]  A1     = '0;
    logic [3:0]  B1     = '0;
    logic        Cin1   = 1'b0;
    logic        busy1, done1, err1, Cout1;
    logic [3:0]  Sum1;
    logic [0:0]  digit_idx1;

    int errors = 0;
    int checks = 0;

    always #5 Clock = ~Clock;

    bcd_serial_add_ctrl #(.DIGITS(4)) dut4 (
        .Clock(Clock), .Resetn(Resetn), .start(start), .A(A), .B(B), .Cin(Cin),
        .busy(busy), .done(done), .err(err), .Sum(Sum), .Cout(Cout),
        .digit_idx(digit_idx)
    );

    bcd_serial_add_ctrl #(.DIGITS(1)) dut1 (
        .Clock(Clock), .Resetn(Resetn), .start(start1), .A(A1), .B(B1), .Cin(Cin1),
        .busy(busy1), .done(done1), .err(err1), .Sum(Sum1), .Cout(Cout1),
        .digit_idx(digit_idx1)
    );

    // ---------------- decimal reference model ----------------
    function automatic int bcd_val(input logic [15:0] v, input int nd);
        int r = 0;
        for (int i = nd - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int v, input int nd);
        logic [15:0] r = '0;
        int x = v;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic ref_add(input logic [15:0] a, input logic [15:0] b, input logic cin,
                           input int nd, output logic [15:0] s, output logic c);
        int lim = 1;
        int total;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        total = bcd_val(a, nd) + bcd_val(b, nd) + int'(cin);
        c = (total >= lim);
        s = to_bcd(total % lim, nd);
    endtask

    function automatic logic [15:0] rand_bcd(input int nd);
        logic [15:0] r = '0;
        for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'($urandom_range(9, 0));
        return r;
    endfunction

    // Drive one operation on the 4-digit instance and observe it up to done.
    // lat counts falling edges sampled after start was presented.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input bit disturb, output int lat, output int busy_cnt,
                         output int overlap, output logic [15:0] part_sum,
                         output logic [1:0] part_idx);
        @(negedge Clock);
        A = a; B = b; Cin = cin; start = 1'b1;
        lat = 0; busy_cnt = 0; overlap = 0; part_sum = 'x; part_idx = 'x;
        do begin
            @(negedge Clock);
            lat++;
            if (busy) busy_cnt++;
            if (busy && done) overlap++;
            if (lat == 3) begin
                part_sum = Sum;
                part_idx = digit_idx;
            end
            if (disturb && !done) begin
                A = 16'($urandom); B = 16'($urandom);
                Cin = 1'($urandom); start = 1'($urandom);
            end else begin
                start = 1'b0;
            end
        end while (!done && lat < 40);
        start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1 Resetn = 1'b0;
        #2;
        checks++;
        if ({busy, done, err, Cout, Sum, digit_idx} !== '0) begin
            errors++;
            $display("FAIL reset4: busy=%b done=%b err=%b Cout=%b Sum=%h idx=%0d required all 0",
                     busy, done, err, Cout, Sum, digit_idx);
        end
        checks++;
        if ({busy1, done1, err1, Cout1, Sum1, digit_idx1} !== '0) begin
            errors++;
            $display("FAIL reset1: busy=%b done=%b err=%b Cout=%b Sum=%h required all 0",
                     busy1, done1, err1, Cout1, Sum1);
        end
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;
    endtask

    task automatic test_basic();
        int lat, bc, ov;
        logic [15:0] ps;
        logic [1:0] pi;
        do_op(16'h1234, 16'h5678, 1'b0, 1'b0, lat, bc, ov, ps, pi);
        checks++;
        if (lat != 5) begin errors++; $display("FAIL basic_latency: got %0d required 5", lat); end
        checks++;
        if (bc != 4) begin errors++; $display("FAIL basic_busy_cycles: got %0d required 4", bc); end
        checks++;
        if (ov != 0) begin errors++; $display("FAIL basic_busy_done_overlap: got %0d required 0", ov); end
        checks++;
        if (ps !== 16'h0012 || pi !== 2'd2) begin
            errors++;
            $display("FAIL basic_partial: Sum=%h idx=%0d required 0012 idx 2", ps, pi);
        end
        checks++;
        if (Sum !== 16'h6912 || Cout !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: Sum=%h Cout=%b err=%b required 6912 0 0", Sum, Cout, err);
        end
        @(negedge Clock);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || Sum !== 16'h6912) begin
            errors++;
            $display("FAIL basic_idle_hold: done=%b busy=%b Sum=%h required 0 0 6912", done, busy, Sum);
        end
    endtask

    task automatic test_ripple();
        int lat, bc, ov;
        logic [15:0] ps;
        logic [1:0] pi;
        do_op(16'h9999, 16'h0001, 1'b0, 1'b0, lat, bc, ov, ps, pi);
        checks++;
        if (Sum !== 16'h0000 || Cout !== 1'b1 || lat != 5) begin
            errors++;
            $display("FAIL ripple_9999_1: Sum=%h Cout=%b lat=%0d required 0000 1 5", Sum, Cout, lat);
        end
        do_op(16'h9999, 16'h9999, 1'b1, 1'b0, lat, bc, ov, ps, pi);
        checks++;
        if (Sum !== 16'h9999 || Cout !== 1'b1) begin
            errors++;
            $display("FAIL ripple_9999_9999_c: Sum=%h Cout=%b required 9999 1", Sum, Cout);
        end
    endtask

    task automatic test_invalid();
        int lat, bc, ov;
        logic [15:0] ps;
        logic [1:0] pi;
        do_op(16'h12A4, 16'h0000, 1'b0, 1'b0, lat, bc, ov, ps, pi);
        checks++;
        if (lat != 1 || err !== 1'b1 || Sum !== 16'h0000 || Cout !== 1'b0 || bc != 0) begin
            errors++;
            $display("FAIL invalid_a: lat=%0d err=%b Sum=%h Cout=%b busy_cycles=%0d required 1 1 0000 0 0",
                     lat, err, Sum, Cout, bc);
        end
        @(negedge Clock);
        checks++;
        if (err !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL invalid_err_hold: err=%b done=%b required 1 0", err, done);
        end
        do_op(16'h0000, 16'hF000, 1'b0, 1'b0, lat, bc, ov, ps, pi);
        checks++;
        if (lat != 1 || err !== 1'b1 || bc != 0) begin
            errors++;
            $display("FAIL invalid_b: lat=%0d err=%b busy_cycles=%0d required 1 1 0", lat, err, bc);
        end
        do_op(16'h0005, 16'h0005, 1'b0, 1'b0, lat, bc, ov, ps, pi);
        checks++;
        if (err !== 1'b0 || Sum !== 16'h0010 || lat != 5) begin
            errors++;
            $display("FAIL invalid_then_valid: err=%b Sum=%h lat=%0d required 0 0010 5", err, Sum, lat);
        end
    endtask

    task automatic test_ignored();
        int lat, bc, ov;
        logic [15:0] ps, a, b, es;
        logic [1:0] pi;
        logic c, ec;
        for (int n = 0; n < 8; n++) begin
            a = rand_bcd(4); b = rand_bcd(4); c = 1'($urandom);
            ref_add(a, b, c, 4, es, ec);
            do_op(a, b, c, 1'b1, lat, bc, ov, ps, pi);
            checks++;
            if (Sum !== es || Cout !== ec || lat != 5) begin
                errors++;
                $display("FAIL ignored_inputs: %h+%h+%b got Sum=%h Cout=%b lat=%0d required %h %b 5",
                         a, b, c, Sum, Cout, lat, es, ec);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge Clock);
        A = 16'h0456; B = 16'h0789; Cin = 1'b0; start = 1'b1;
        lat = 0;
        do begin @(negedge Clock); lat++; end while (!done && lat < 40);
        checks++;
        if (lat != 5 || Sum !== 16'h1245 || Cout !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: lat=%0d Sum=%h Cout=%b required 5 1245 0", lat, Sum, Cout);
        end
        A = 16'h5000; B = 16'h5000; Cin = 1'b1;
        @(negedge Clock);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_idle: busy=%b done=%b required 1 0", busy, done);
        end
        start = 1'b0;
        lat = 1;
        do begin @(negedge Clock); lat++; end while (!done && lat < 40);
        checks++;
        if (lat != 5 || Sum !== 16'h0001 || Cout !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: lat=%0d Sum=%h Cout=%b required 5 0001 1", lat, Sum, Cout);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc, ov, seen_done;
        logic [15:0] ps;
        logic [1:0] pi;
        @(negedge Clock);
        A = 16'h1234; B = 16'h5678; Cin = 1'b0; start = 1'b1;
        @(negedge Clock); start = 1'b0;
        repeat (2) @(negedge Clock);
        Resetn = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, Cout, Sum, digit_idx} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: busy=%b done=%b err=%b Cout=%b Sum=%h idx=%0d required all 0",
                     busy, done, err, Cout, Sum, digit_idx);
        end
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clock);
            if (done || busy) seen_done++;
        end
        Resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            if (done || busy) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL reset_mid_no_done: activity samples=%0d required 0", seen_done);
        end
        do_op(16'h1234, 16'h5678, 1'b0, 1'b0, lat, bc, ov, ps, pi);
        checks++;
        if (Sum !== 16'h6912 || Cout !== 1'b0 || lat != 5) begin
            errors++;
            $display("FAIL reset_mid_recover: Sum=%h Cout=%b lat=%0d required 6912 0 5", Sum, Cout, lat);
        end
    endtask

    task automatic test_random4();
        int lat, bc, ov;
        logic [15:0] ps, a, b, es;
        logic [1:0] pi;
        logic c, ec;
        for (int n = 0; n < 20; n++) begin
            a = rand_bcd(4); b = rand_bcd(4); c = 1'($urandom);
            ref_add(a, b, c, 4, es, ec);
            do_op(a, b, c, 1'b0, lat, bc, ov, ps, pi);
            checks++;
            if (Sum !== es || Cout !== ec || err !== 1'b0 || lat != 5 || bc != 4 || ov != 0) begin
                errors++;
                $display("FAIL random4: %h+%h+%b got Sum=%h Cout=%b err=%b lat=%0d busy=%0d required %h %b 0 5 4",
                         a, b, c, Sum, Cout, err, lat, bc, es, ec);
            end
        end
    endtask

    task automatic test_random1();
        int lat;
        logic [15:0] es;
        logic [3:0] a, b;
        logic c, ec;
        for (int n = 0; n < 20; n++) begin
            a = 4'($urandom_range(9, 0)); b = 4'($urandom_range(9, 0)); c = 1'($urandom);
            ref_add({12'h000, a}, {12'h000, b}, c, 1, es, ec);
            @(negedge Clock);
            A1 = a; B1 = b; Cin1 = c; start1 = 1'b1;
            lat = 0;
            do begin @(negedge Clock); start1 = 1'b0; lat++; end while (!done1 && lat < 40);
            checks++;
            if (Sum1 !== es[3:0] || Cout1 !== ec || err1 !== 1'b0 || lat != 2) begin
                errors++;
                $display("FAIL random1: %h+%h+%b got Sum=%h Cout=%b err=%b lat=%0d required %h %b 0 2",
                         a, b, c, Sum1, Cout1, err1, lat, es[3:0], ec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ripple();
        test_invalid();
        test_ignored();
        test_back_to_back();
        test_reset_mid();
        test_random4();
        test_random1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
